// File: rtl/dmem_bus_if_if.sv
// MEM-stage request/response and data-bus control signals of the load/store unit.
// The slave modport is the bus interface unit; the master modport is the pipeline plus memory side.
interface dmem_bus_if_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 req_valid;
  logic                 req_write;
  logic [1:0]           req_size;
  logic                 req_signed;
  logic [BIT_WIDTH-1:0] req_addr;
  logic [BIT_WIDTH-1:0] req_wdata;
  logic                 stall;
  logic [BIT_WIDTH-1:0] rdata;
  logic                 rdata_valid;
  logic                 misalign;
  logic                 timeout;
  logic [BIT_WIDTH-1:0] DAD;
  logic                 MREQ;
  logic                 WRITE;
  logic [1:0]           SIZE;
  logic                 ACKD_n;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ACKD_n,
    output stall, rdata, rdata_valid, misalign, timeout, DAD, MREQ, WRITE, SIZE
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ACKD_n,
    input  stall, rdata, rdata_valid, misalign, timeout, DAD, MREQ, WRITE, SIZE
  );
endinterface

// File: rtl/dmem_bus_if.sv
// Data-memory bus interface: IDLE/BUS/RESP access FSM, 2-cycle minimum access, ACKD_n wait states
// stretch stall; load data extended on capture; aborts after TIMEOUT_CYCLES unacknowledged cycles.
module dmem_bus_if #(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_bus_if_if.slave         bus,
  inout  wire  [BIT_WIDTH-1:0] DDT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] addr_q;
  logic [BIT_WIDTH-1:0] wdata_q;
  logic [BIT_WIDTH-1:0] rdata_q;
  logic [1:0]           size_q;
  logic                 write_q;
  logic                 signed_q;
  logic [7:0]           cnt_q;

  logic                 req_legal;
  logic                 accept;
  logic                 ack;
  logic                 cnt_last;
  logic                 ddt_oe;
  logic [BIT_WIDTH-1:0] load_ext;

  always_comb begin
    req_legal = 1'b0;
    case (bus.req_size)
      2'b00:   req_legal = (bus.req_addr[1:0] == 2'b00);
      2'b01:   req_legal = (bus.req_addr[0] == 1'b0);
      2'b10:   req_legal = 1'b1;
      default: req_legal = 1'b0;
    endcase
  end

  assign accept   = (state_q == IDLE) && bus.req_valid && req_legal;
  assign ack      = (state_q == BUS) && !bus.ACKD_n;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    load_ext = DDT;
    case (size_q)
      2'b01:   load_ext = {{(BIT_WIDTH-16){signed_q & DDT[15]}}, DDT[15:0]};
      2'b10:   load_ext = {{(BIT_WIDTH-8){signed_q & DDT[7]}}, DDT[7:0]};
      default: load_ext = DDT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = BUS;
      BUS: begin
        // Acknowledge takes priority over a timeout landing in the same cycle.
        if (ack) begin
          state_d = RESP;
        end else if (cnt_last) begin
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall       = 1'b0;
    bus.misalign    = 1'b0;
    bus.timeout     = 1'b0;
    bus.rdata_valid = 1'b0;
    bus.MREQ        = 1'b0;
    ddt_oe          = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            bus.stall    = req_legal;
            bus.misalign = !req_legal;
          end
        end
        BUS: begin
          bus.stall   = 1'b1;
          bus.MREQ    = 1'b1;
          ddt_oe      = write_q;
          bus.timeout = bus.ACKD_n && cnt_last;
        end
        RESP:    bus.rdata_valid = !write_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      if (accept) begin
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        size_q   <= bus.req_size;
        write_q  <= bus.req_write;
        signed_q <= bus.req_signed;
        cnt_q    <= 8'd0;
      end
      if (state_q == BUS) begin
        if (ack) begin
          if (!write_q) rdata_q <= load_ext;
        end else if (cnt_last) begin
          rdata_q <= '0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign bus.DAD   = addr_q;
  assign bus.SIZE  = size_q;
  assign bus.WRITE = write_q;
  assign bus.rdata = rdata_q;
  assign DDT       = ddt_oe ? wdata_q : {BIT_WIDTH{1'bz}};

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed bench for dmem_bus_if with TIMEOUT_CYCLES=4; inputs change on the falling edge,
// outputs are checked 1ns later.
module tb_dmem_bus_if;
  logic        clk;
  logic        rst;
  logic        tb_oe;
  logic [31:0] tb_dat;
  wire  [31:0] ddt;
  int          total;
  int          bad;

  dmem_bus_if_if #(.BIT_WIDTH(32)) bif();

  dmem_bus_if #(.BIT_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave),
    .DDT (ddt)
  );

  assign ddt = tb_oe ? tb_dat : 32'hzzzz_zzzz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input logic v, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    bif.req_valid  = v;
    bif.req_write  = w;
    bif.req_size   = sz;
    bif.req_signed = sg;
    bif.req_addr   = a;
    bif.req_wdata  = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0);
    bif.ACKD_n = 1'b0;
    tb_oe = 1'b1;
    tb_dat = 32'hA5A5_A5A5;
    next_cyc();
    next_cyc();
    #1;
    total++; if (bif.stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", bif.stall); end
    total++; if (bif.MREQ !== 1'b0) begin bad++; $display("FAIL rst_mreq: got %b want 0", bif.MREQ); end
    total++; if (bif.DAD !== 32'h0) begin bad++; $display("FAIL rst_dad: got %h want 0", bif.DAD); end
    total++; if ({bif.WRITE, bif.SIZE} !== 3'b000) begin bad++; $display("FAIL rst_write_size: got %b want 000", {bif.WRITE, bif.SIZE}); end
    total++; if (bif.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bif.rdata); end
    total++; if ({bif.rdata_valid, bif.misalign, bif.timeout} !== 3'b000) begin bad++; $display("FAIL rst_pulses: got %b want 000", {bif.rdata_valid, bif.misalign, bif.timeout}); end
    total++; if (ddt !== 32'hA5A5_A5A5) begin bad++; $display("FAIL rst_ddt: got %h want a5a5a5a5", ddt); end
    next_cyc();
    rst = 1'b0;
    bif.req_valid = 1'b0;
    #1;
    next_cyc();
    #1;
    total++; if ({bif.MREQ, bif.stall, bif.rdata_valid} !== 3'b000) begin bad++; $display("FAIL idle_ack_ignored: got %b want 000", {bif.MREQ, bif.stall, bif.rdata_valid}); end
    bif.ACKD_n = 1'b1;
    tb_oe = 1'b0;
  endtask

  task automatic test_signed_byte();
    int stall_n = 0;
    int vld_n = 0;
    next_cyc();
    set_req(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0);
    #1;
    stall_n += int'(bif.stall);
    total++; if ({bif.MREQ, bif.misalign} !== 2'b00) begin bad++; $display("FAIL sb_idle: got %b want 00", {bif.MREQ, bif.misalign}); end
    next_cyc();
    tb_oe = 1'b1; tb_dat = 32'h0000_0080; bif.ACKD_n = 1'b0;
    #1;
    stall_n += int'(bif.stall);
    total++; if ({bif.MREQ, bif.WRITE, bif.SIZE} !== 4'b1010) begin bad++; $display("FAIL sb_bus_ctl: got %b want 1010", {bif.MREQ, bif.WRITE, bif.SIZE}); end
    total++; if (bif.DAD !== 32'h0000_0103) begin bad++; $display("FAIL sb_dad: got %h want 00000103", bif.DAD); end
    next_cyc();
    bif.req_valid = 1'b0; bif.ACKD_n = 1'b1; tb_oe = 1'b0;
    #1;
    stall_n += int'(bif.stall);
    vld_n += int'(bif.rdata_valid);
    total++; if (bif.rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL sb_rdata: got %h want ffffff80", bif.rdata); end
    total++; if (bif.MREQ !== 1'b0) begin bad++; $display("FAIL sb_resp_mreq: got %b want 0", bif.MREQ); end
    next_cyc();
    #1;
    stall_n += int'(bif.stall);
    vld_n += int'(bif.rdata_valid);
    total++; if (stall_n !== 2) begin bad++; $display("FAIL sb_stall_cycles: got %0d want 2", stall_n); end
    total++; if (vld_n !== 1) begin bad++; $display("FAIL sb_valid_pulses: got %0d want 1", vld_n); end
    total++; if (bif.rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL sb_rdata_hold: got %h want ffffff80", bif.rdata); end
  endtask

  task automatic test_word_store();
    int mreq_n = 0;
    int vld_n = 0;
    next_cyc();
    set_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    #1;
    total++; if (bif.stall !== 1'b1) begin bad++; $display("FAIL st_idle_stall: got %b want 1", bif.stall); end
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      bif.ACKD_n = (i == 3) ? 1'b0 : 1'b1;
      #1;
      mreq_n += int'(bif.MREQ);
      vld_n += int'(bif.rdata_valid);
      total++; if (ddt !== 32'hDEAD_BEEF) begin bad++; $display("FAIL st_ddt%0d: got %h want deadbeef", i, ddt); end
      total++; if ({bif.WRITE, bif.SIZE, bif.stall} !== 4'b1001) begin bad++; $display("FAIL st_ctl%0d: got %b want 1001", i, {bif.WRITE, bif.SIZE, bif.stall}); end
    end
    next_cyc();
    bif.req_valid = 1'b0; bif.ACKD_n = 1'b1; tb_oe = 1'b1; tb_dat = 32'h5A5A_5A5A;
    #1;
    vld_n += int'(bif.rdata_valid);
    total++; if (mreq_n !== 4) begin bad++; $display("FAIL st_mreq_cycles: got %0d want 4", mreq_n); end
    total++; if (vld_n !== 0) begin bad++; $display("FAIL st_no_valid: got %0d want 0", vld_n); end
    total++; if (ddt !== 32'h5A5A_5A5A) begin bad++; $display("FAIL st_ddt_release: got %h want 5a5a5a5a", ddt); end
    total++; if ({bif.MREQ, bif.stall} !== 2'b00) begin bad++; $display("FAIL st_resp: got %b want 00", {bif.MREQ, bif.stall}); end
    total++; if (bif.rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL st_rdata_kept: got %h want ffffff80", bif.rdata); end
    tb_oe = 1'b0;
  endtask

  task automatic test_half_misalign();
    next_cyc();
    set_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0);
    next_cyc();
    tb_oe = 1'b1; tb_dat = 32'h0000_F00D; bif.ACKD_n = 1'b0;
    #1;
    total++; if ({bif.MREQ, bif.SIZE} !== 3'b101) begin bad++; $display("FAIL hl_bus: got %b want 101", {bif.MREQ, bif.SIZE}); end
    next_cyc();
    bif.req_valid = 1'b0; bif.ACKD_n = 1'b1; tb_oe = 1'b0;
    #1;
    total++; if (bif.rdata !== 32'h0000_F00D || bif.rdata_valid !== 1'b1) begin bad++; $display("FAIL hl_rdata: got %h/%b want 0000f00d/1", bif.rdata, bif.rdata_valid); end
    next_cyc();
    set_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0);
    #1;
    total++; if ({bif.misalign, bif.stall, bif.MREQ} !== 3'b100) begin bad++; $display("FAIL mis_word: got %b want 100", {bif.misalign, bif.stall, bif.MREQ}); end
    next_cyc();
    set_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0101, 32'h0);
    #1;
    total++; if ({bif.misalign, bif.stall, bif.MREQ} !== 3'b100) begin bad++; $display("FAIL mis_half: got %b want 100", {bif.misalign, bif.stall, bif.MREQ}); end
    next_cyc();
    set_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
    #1;
    total++; if ({bif.misalign, bif.stall, bif.MREQ} !== 3'b100) begin bad++; $display("FAIL mis_size3: got %b want 100", {bif.misalign, bif.stall, bif.MREQ}); end
    next_cyc();
    bif.req_valid = 1'b0;
    #1;
    total++; if ({bif.misalign, bif.MREQ} !== 2'b00) begin bad++; $display("FAIL mis_after: got %b want 00", {bif.misalign, bif.MREQ}); end
  endtask

  task automatic test_load_extension();
    logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b10, 2'b00};
    logic        sg [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] ad [4] = '{32'h100, 32'h101, 32'h102, 32'h104};
    logic [31:0] dd [4] = '{32'h1234_8001, 32'hABCD_EFF0, 32'hFFFF_FF7F, 32'h8000_0001};
    logic [31:0] ex [4] = '{32'hFFFF_8001, 32'h0000_00F0, 32'h0000_007F, 32'h8000_0001};
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      set_req(1'b1, 1'b0, sz[i], sg[i], ad[i], 32'h0);
      next_cyc();
      tb_oe = 1'b1; tb_dat = dd[i]; bif.ACKD_n = 1'b0;
      next_cyc();
      bif.req_valid = 1'b0; bif.ACKD_n = 1'b1; tb_oe = 1'b0;
      #1;
      total++; if (bif.rdata !== ex[i] || bif.rdata_valid !== 1'b1) begin bad++; $display("FAIL ext%0d: got %h/%b want %h/1", i, bif.rdata, bif.rdata_valid, ex[i]); end
    end
  endtask

  task automatic test_timeout();
    next_cyc();
    set_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0300, 32'h0);
    bif.ACKD_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      bif.req_valid = 1'b0;
      #1;
      total++; if ({bif.MREQ, bif.stall, bif.timeout} !== {2'b11, (i == 3)}) begin bad++; $display("FAIL to_bus%0d: got %b want %b", i, {bif.MREQ, bif.stall, bif.timeout}, {2'b11, (i == 3)}); end
    end
    next_cyc();
    #1;
    total++; if ({bif.MREQ, bif.stall, bif.timeout, bif.rdata_valid} !== 4'b0000) begin bad++; $display("FAIL to_after: got %b want 0000", {bif.MREQ, bif.stall, bif.timeout, bif.rdata_valid}); end
    total++; if (bif.rdata !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h want 0", bif.rdata); end
    next_cyc();
    set_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0304, 32'h0);
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      bif.req_valid = 1'b0;
      if (i == 3) begin
        bif.ACKD_n = 1'b0; tb_oe = 1'b1; tb_dat = 32'hCAFE_F00D;
      end
      #1;
    end
    total++; if ({bif.MREQ, bif.timeout} !== 2'b10) begin bad++; $display("FAIL to_ack_wins: got %b want 10", {bif.MREQ, bif.timeout}); end
    next_cyc();
    bif.ACKD_n = 1'b1; tb_oe = 1'b0;
    #1;
    total++; if (bif.rdata !== 32'hCAFE_F00D || bif.rdata_valid !== 1'b1) begin bad++; $display("FAIL to_ack_data: got %h/%b want cafef00d/1", bif.rdata, bif.rdata_valid); end
  endtask

  task automatic test_reset_abort();
    next_cyc();
    set_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0400, 32'h1122_3344);
    bif.ACKD_n = 1'b1;
    next_cyc();
    #1;
    total++; if (bif.MREQ !== 1'b1 || ddt !== 32'h1122_3344) begin bad++; $display("FAIL ab_bus1: got %b/%h want 1/11223344", bif.MREQ, ddt); end
    next_cyc();
    rst = 1'b1; bif.req_valid = 1'b0;
    #1;
    total++; if ({bif.stall, bif.timeout, bif.misalign, bif.rdata_valid} !== 4'b0000) begin bad++; $display("FAIL ab_rst_cycle: got %b want 0000", {bif.stall, bif.timeout, bif.misalign, bif.rdata_valid}); end
    next_cyc();
    rst = 1'b0; tb_oe = 1'b1; tb_dat = 32'h5A5A_5A5A;
    #1;
    total++; if ({bif.MREQ, bif.stall, bif.timeout, bif.rdata_valid} !== 4'b0000) begin bad++; $display("FAIL ab_after: got %b want 0000", {bif.MREQ, bif.stall, bif.timeout, bif.rdata_valid}); end
    total++; if (ddt !== 32'h5A5A_5A5A) begin bad++; $display("FAIL ab_ddt: got %h want 5a5a5a5a", ddt); end
    total++; if (bif.rdata !== 32'h0 || bif.WRITE !== 1'b0) begin bad++; $display("FAIL ab_cleared: got %h/%b want 0/0", bif.rdata, bif.WRITE); end
    next_cyc();
    tb_oe = 1'b0;
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0403, 32'h0);
    next_cyc();
    tb_oe = 1'b1; tb_dat = 32'h0000_00C3; bif.ACKD_n = 1'b0;
    #1;
    total++; if (bif.MREQ !== 1'b1 || bif.DAD !== 32'h0000_0403) begin bad++; $display("FAIL ab_next_bus: got %b/%h want 1/00000403", bif.MREQ, bif.DAD); end
    next_cyc();
    bif.req_valid = 1'b0; bif.ACKD_n = 1'b1; tb_oe = 1'b0;
    #1;
    total++; if (bif.rdata !== 32'h0000_00C3 || bif.rdata_valid !== 1'b1) begin bad++; $display("FAIL ab_next_data: got %h/%b want 000000c3/1", bif.rdata, bif.rdata_valid); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] stall_seq = '0;
    logic [6:0] mreq_seq = '0;
    int vld_n = 0;
    logic [31:0] second_data = 32'h0;
    for (int c = 0; c < 7; c++) begin
      next_cyc();
      case (c)
        0: set_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0);
        1: begin bif.ACKD_n = 1'b0; tb_oe = 1'b1; tb_dat = 32'h1234_5678; end
        2: begin
          bif.ACKD_n = 1'b1; tb_oe = 1'b0;
          set_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0204, 32'h0);
        end
        4: begin bif.ACKD_n = 1'b0; tb_oe = 1'b1; tb_dat = 32'h9ABC_DEF0; end
        5: begin bif.ACKD_n = 1'b1; tb_oe = 1'b0; bif.req_valid = 1'b0; end
        default: ;
      endcase
      #1;
      stall_seq[6-c] = bif.stall;
      mreq_seq[6-c] = bif.MREQ;
      vld_n += int'(bif.rdata_valid);
      if (c == 2) begin
        total++; if (bif.rdata !== 32'h1234_5678) begin bad++; $display("FAIL b2b_first: got %h want 12345678", bif.rdata); end
      end
      if (c == 5) second_data = bif.rdata;
    end
    total++; if (stall_seq !== 7'b1101100) begin bad++; $display("FAIL b2b_stall_seq: got %b want 1101100", stall_seq); end
    total++; if (mreq_seq !== 7'b0100100) begin bad++; $display("FAIL b2b_mreq_seq: got %b want 0100100", mreq_seq); end
    total++; if (vld_n !== 2) begin bad++; $display("FAIL b2b_valid_count: got %0d want 2", vld_n); end
    total++; if (second_data !== 32'h9ABC_DEF0) begin bad++; $display("FAIL b2b_second: got %h want 9abcdef0", second_data); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    tb_oe = 1'b0;
    tb_dat = 32'h0;
    bif.ACKD_n = 1'b1;
    set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_signed_byte();
    test_word_store();
    test_half_misalign();
    test_load_extension();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
